// File: rtl/vision_test_sequencer.sv
// Session controller for the vision test. Steps the acuity level from 4.0
// upward, presents one random symbol direction per trial, judges the
// debounced direction keys and reports the final acuity as 2-digit BCD.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for the first start pulse after reset
// SHOW     | symbol visible, waiting for a key or the answer timeout
// FEEDBACK | trial result held on fb_correct, then level decision
// DONE     | final acuity shown, display blinks until restart
module vision_test_sequencer #(
  parameter int TIMEOUT_CYCLES   = 50_000_000,
  parameter int FEEDBACK_CYCLES  = 5_000_000,
  parameter int TRIALS_PER_LEVEL = 3,
  parameter int PASS_HITS        = 2,
  parameter int NUM_LEVELS       = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_pulse,
  input  logic [3:0] key_pulse,
  output logic [3:0] level,
  output logic [1:0] sym_dir,
  output logic       show_en,
  output logic       fb_valid,
  output logic       fb_correct,
  output logic [7:0] vision_bcd,
  output logic       ctr_signal,
  output logic       result_valid
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FEEDBACK_CYCLES > 1) ? $clog2(FEEDBACK_CYCLES) : 1;
  localparam int CW = $clog2(TRIALS_PER_LEVEL + 1);

  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST     = FW'(FEEDBACK_CYCLES - 1);
  localparam logic [CW-1:0] HITS_NEED  = CW'(PASS_HITS);
  localparam logic [CW-1:0] MISS_MAX   = CW'(TRIALS_PER_LEVEL - PASS_HITS);
  localparam logic [3:0]    LAST_LEVEL = 4'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, FEEDBACK, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    level_nxt;
  logic [1:0]    sym_dir_nxt;
  logic          fb_correct_nxt;
  logic [CW-1:0] hits, hits_nxt, misses, misses_nxt, trials, trials_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic [7:0]    lfsr, lfsr_nxt;
  logic [7:0]    result, result_nxt;
  logic          key_any, key_single, judge;

  function automatic logic [7:0] level_to_bcd(input logic [3:0] l);
    logic [7:0] v;
    if (l < 4'd10) v = {4'h4, l};
    else           v = {4'h5, l - 4'd10};
    return v;
  endfunction

  // Exactly one key bit set; the direction code of a key is its bit index.
  assign key_any    = |key_pulse;
  assign key_single = key_any && ((key_pulse & (key_pulse - 4'd1)) == 4'd0);
  assign judge      = key_single && key_pulse[sym_dir];
  // x^8+x^6+x^5+x^4+1, shifted left, never reaches zero from 8'h5A.
  assign lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      level      <= 4'd0;
      sym_dir    <= 2'd0;
      fb_correct <= 1'b0;
      hits       <= '0;
      misses     <= '0;
      trials     <= '0;
      tcnt       <= '0;
      fcnt       <= '0;
      lfsr       <= 8'h5A;
      result     <= 8'h00;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      sym_dir    <= sym_dir_nxt;
      fb_correct <= fb_correct_nxt;
      hits       <= hits_nxt;
      misses     <= misses_nxt;
      trials     <= trials_nxt;
      tcnt       <= tcnt_nxt;
      fcnt       <= fcnt_nxt;
      lfsr       <= lfsr_nxt;
      result     <= result_nxt;
    end
  end

  // Next-state logic; start_pulse overrides everything else.
  always_comb begin
    state_nxt      = state;
    level_nxt      = level;
    sym_dir_nxt    = sym_dir;
    fb_correct_nxt = fb_correct;
    hits_nxt       = hits;
    misses_nxt     = misses;
    trials_nxt     = trials;
    tcnt_nxt       = tcnt;
    fcnt_nxt       = fcnt;
    result_nxt     = result;

    if (start_pulse) begin
      state_nxt   = SHOW;
      level_nxt   = 4'd0;
      hits_nxt    = '0;
      misses_nxt  = '0;
      trials_nxt  = '0;
      tcnt_nxt    = '0;
      sym_dir_nxt = lfsr[1:0];
    end else begin
      case (state)
        SHOW: begin
          if (key_any || (tcnt == T_LAST)) begin
            state_nxt      = FEEDBACK;
            fcnt_nxt       = '0;
            fb_correct_nxt = judge;
            trials_nxt     = trials + 1'b1;
            if (judge) hits_nxt   = hits + 1'b1;
            else       misses_nxt = misses + 1'b1;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
        FEEDBACK: begin
          if (fcnt == F_LAST) begin
            if (hits == HITS_NEED) begin
              if (level == LAST_LEVEL) begin
                state_nxt  = DONE;
                result_nxt = level_to_bcd(level);
              end else begin
                state_nxt   = SHOW;
                level_nxt   = level + 4'd1;
                hits_nxt    = '0;
                misses_nxt  = '0;
                trials_nxt  = '0;
                tcnt_nxt    = '0;
                sym_dir_nxt = lfsr[1:0];
              end
            end else if (misses > MISS_MAX) begin
              state_nxt  = DONE;
              result_nxt = (level == 4'd0) ? 8'h00 : level_to_bcd(level - 4'd1);
            end else begin
              state_nxt   = SHOW;
              tcnt_nxt    = '0;
              sym_dir_nxt = lfsr[1:0];
            end
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign show_en      = (state == SHOW);
  assign fb_valid     = (state == FEEDBACK);
  assign result_valid = (state == DONE);
  assign ctr_signal   = (state == DONE);
  assign vision_bcd   = (state == DONE) ? result : level_to_bcd(level);

endmodule
